acc_cpu_param: RTL



---
 rtl/acc_cpu_param.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_param.sv
// acc_cpu_param: parametrised accumulator CPU with a req/ready memory port.
//
// Four instructions, opcode in the top two bits of the instruction word and
// operand in the low ADDR_W bits:
//   00 NOR  accu = ~(accu | M[op])       carry unchanged
//   01 ADD  {carry, accu} = accu + M[op]
//   10 STA  M[op] = accu
//   11 JCC  carry == 0 -> pc = op; otherwise carry = 0, pc = pc + 1
//
// Parameters:
//   DATA_W     accumulator / memory word / instruction width
//   ADDR_W     address and pc width (must satisfy ADDR_W <= DATA_W - 2)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   mem_req    memory transaction request
//   mem_we     1 = write, 0 = read (meaningful while mem_req = 1)
//   mem_addr   transaction address
//   mem_wdata  write data
//   mem_rdata  read data, valid when mem_ready = 1
//   mem_ready  completes the current transaction at the rising edge
//   carry      accumulator carry flag
//   pc         current program counter
//   halted     core halted (only possible with ACC_CPU_HALT_EN)
//
// Build option: define ACC_CPU_HALT_EN to turn a taken self-jump into an
// absorbing HALT state. Without it the self-jump simply loops forever.
//
// Every output is a register or a decode of the state register, so there is
// no combinational path from mem_ready/mem_rdata to any output.

module acc_cpu_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              carry,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

`ifdef ACC_CPU_HALT_EN
  typedef enum logic [2:0] {StIdle, StFetch, StExec, StLoad, StStore, StHalt} state_e;
`else
  typedef enum logic [2:0] {StIdle, StFetch, StExec, StLoad, StStore} state_e;
`endif

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [DATA_W-1:0]   accu_q;
  logic                carry_q;
  logic [1:0]          opcode_q;
  logic [ADDR_W-1:0]   operand_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  // Only opcode and operand of the fetched word are kept; the middle bits
  // carry no meaning.
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W:0]     sum_d;
  logic [DATA_W-1:0]   nor_d;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign sum_d  = {1'b0, accu_q} + {1'b0, mem_rdata};
  assign nor_d  = ~(accu_q | mem_rdata);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      accu_q    <= '0;
      carry_q   <= 1'b0;
      opcode_q  <= 2'b00;
      operand_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          addr_q  <= pc_q;
          state_q <= StFetch;
        end
        StFetch: begin
          if (mem_ready) begin
            opcode_q  <= mem_rdata[DATA_W-1:DATA_W-2];
            operand_q <= mem_rdata[ADDR_W-1:0];
            state_q   <= StExec;
          end
        end
        StExec: begin
          case (opcode_q)
            2'b00, 2'b01: begin
              addr_q  <= operand_q;
              state_q <= StLoad;
            end
            2'b10: begin
              addr_q  <= operand_q;
              wdata_q <= accu_q;
              state_q <= StStore;
            end
            default: begin
              if (!carry_q) begin
`ifdef ACC_CPU_HALT_EN
                // A taken jump onto itself can never make progress: park.
                if (operand_q == pc_q) begin
                  state_q <= StHalt;
                end else begin
                  pc_q    <= operand_q;
                  addr_q  <= operand_q;
                  state_q <= StFetch;
                end
`else
                pc_q    <= operand_q;
                addr_q  <= operand_q;
                state_q <= StFetch;
`endif
              end else begin
                carry_q <= 1'b0;
                pc_q    <= pc_inc;
                addr_q  <= pc_inc;
                state_q <= StFetch;
              end
            end
          endcase
        end
        StLoad: begin
          if (mem_ready) begin
            if (opcode_q[0]) begin
              {carry_q, accu_q} <= sum_d;
            end else begin
              accu_q <= nor_d;
            end
            pc_q    <= pc_inc;
            addr_q  <= pc_inc;
            state_q <= StFetch;
          end
        end
        StStore: begin
          if (mem_ready) begin
            pc_q    <= pc_inc;
            addr_q  <= pc_inc;
            state_q <= StFetch;
          end
        end
`ifdef ACC_CPU_HALT_EN
        StHalt: begin
          state_q <= StHalt;
        end
`endif
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_req   = (state_q == StFetch) || (state_q == StLoad) || (state_q == StStore);
  assign mem_we    = (state_q == StStore);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign carry     = carry_q;
  assign pc        = pc_q;

`ifdef ACC_CPU_HALT_EN
  assign halted = (state_q == StHalt);
`else
  assign halted = 1'b0;
`endif

endmodule
